fir_stream: RTL and testbench

FIR_STREAM -- requirements
Module: fir_stream

---
 rtl/fir_stream_pkg.sv | 20 ++
 rtl/fir_stream_mac.sv | 41 ++++
 rtl/fir_stream.sv | 152 +++++++++++++++
 tb/tb_fir_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared FSM state type and accumulator sizing helper
// for the time-multiplexed streaming FIR filter.
package fir_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Sum of TAPS full-width products cannot exceed this width.
  function automatic int acc_w(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_stream_mac.sv
// fir_stream_mac: single signed multiplier plus accumulator.
// Ports: clk, rst (sync, low), i_clr, i_en, i_x, i_c -> o_acc_nxt.
module fir_stream_mac
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_c,
  output logic signed [ACC_W-1:0]  o_acc_nxt
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = i_x * i_c;

  // Sum including the current tap, so the top can
  // register the final result on the last MAC edge.
  assign o_acc_nxt = r_acc
    + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/fir_stream.sv
// fir_stream: streaming FIR, one multiplier, TAPS MAC cycles per sample.
// Ports: clk, rst, enable, in_*/out_* valid-ready streams, coef_* write, ovf, sample_cnt.
module fir_stream
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4,
  parameter int SHIFT  = 8,
  parameter int SAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       ovf,
  output logic [15:0]                sample_cnt
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]            r_idx;
  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [COEF_W-1:0] r_c [TAPS];
  logic signed [DATA_W-1:0] r_out;
  logic                     r_ovf;
  logic [15:0]              r_cnt;

  logic w_accept;
  logic w_mac_en;
  logic w_last;
  logic w_deliver;
  logic w_coef_wr;
  logic w_fit;

  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  w_sh;
  logic signed [DATA_W-1:0] w_y;

  assign in_ready  = rst & enable & !coef_we
                   & (r_state == IDLE);
  assign w_accept  = in_ready & in_valid;
  assign w_mac_en  = enable & (r_state == MAC);
  assign w_last    = w_mac_en
                   & (r_idx == AW'(TAPS-1));
  assign w_deliver = enable & out_ready
                   & (r_state == OUT);
  assign w_coef_wr = coef_we & (r_state == IDLE)
                   & (int'(coef_addr) < TAPS);

  assign out_valid  = (r_state == OUT);
  assign out_data   = r_out;
  assign ovf        = r_ovf;
  assign sample_cnt = r_cnt;

  fir_stream_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_en      (w_mac_en),
    .i_x       (r_x[r_idx]),
    .i_c       (r_c[r_idx]),
    .o_acc_nxt (w_acc_nxt)
  );

  // Value fits DATA_W when every bit above the output
  // sign bit is a copy of it.
  assign w_sh  = w_acc_nxt >>> SHIFT;
  assign w_fit = (w_sh[ACC_W-1:DATA_W-1]
               == {(ACC_W-DATA_W+1){w_sh[DATA_W-1]}});

  always_comb begin
    w_y = w_sh[DATA_W-1:0];
    if (SAT != 0 && !w_fit) begin
      w_y = w_sh[ACC_W-1]
          ? {1'b1, {(DATA_W-1){1'b0}}}
          : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = MAC;
      MAC:     if (w_last)    w_state_nxt = OUT;
      OUT:     if (w_deliver) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx <= '0;
      r_out <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
      r_c[0] <= COEF_W'(1 << SHIFT);
    end else begin
      if (w_accept) begin
        r_idx  <= '0;
        r_x[0] <= in_data;
        for (int k = TAPS-1; k > 0; k--) begin
          r_x[k] <= r_x[k-1];
        end
      end
      if (w_mac_en) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_out <= w_y;
        if (!w_fit) begin
          r_ovf <= 1'b1;
        end
      end
      if (w_deliver) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_coef_wr) begin
        r_c[coef_addr] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: scoreboard bench for fir_stream (default parameters).
// A reference model queues expected outputs on every accepted sample.
module tb_fir_stream;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 4;
  localparam int SH   = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          enable    = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic          coef_we   = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [1:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          ovf;
  logic [DW-1:0] out_data;
  logic [15:0]   sample_cnt;

  int  n_chk = 0;
  int  n_err = 0;
  int  m_c [TAPS];
  int  m_x [TAPS];
  int  q [$];
  int  exp_cnt;
  bit  m_ovf;
  time t_acc;
  time t_prev;

  always #5 clk = ~clk;

  fir_stream dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .ovf        (ovf),
    .sample_cnt (sample_cnt)
  );

  task automatic chk(
    input string              tag,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d",
               tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mreset();
    for (int k = 0; k < TAPS; k++) begin
      m_c[k] = 0;
      m_x[k] = 0;
    end
    m_c[0] = 1 << SH;
    q.delete();
    exp_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    mreset();
  endtask

  task automatic mpush(input int x);
    longint s;
    s = 0;
    for (int k = TAPS-1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = x;
    for (int k = 0; k < TAPS; k++)
      s += longint'(m_c[k]) * longint'(m_x[k]);
    s = s >>> SH;
    if (s > 32767) begin
      s = 32767;
      m_ovf = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      m_ovf = 1'b1;
    end
    q.push_back(int'(s));
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = a[1:0];
    coef_data = d[15:0];
    tick();
    coef_we = 1'b0;
    m_c[a] = d;
  endtask

  task automatic send(input int x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x[15:0];
    #0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("acc_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      t_prev = t_acc;
      t_acc  = $time;
      #1;
      in_valid = 1'b0;
      mpush(x);
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take(input string tag);
    int e;
    if (q.size() == 0) begin
      chk({tag, "_q"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk(tag, $signed(out_data), e);
    end
  endtask

  task automatic xfer(input int x, input string tag);
    int c;
    send(x);
    wait_out(c);
    chk({tag, "_lat"}, c, TAPS+1);
    take(tag);
    tick();
    exp_cnt++;
    chk({tag, "_cnt"}, sample_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c;
    tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", sample_cnt, 0);
    rst = 1'b1;
    mreset();
    #1;
    chk("idle_rdy", in_ready, 1);

    xfer(5, "id0");
    xfer(-3, "id1");
    xfer(100, "id2");
    chk("id_cnt", sample_cnt, 3);
    chk("id_ovf", ovf, 0);

    do_reset();
    for (int a = 0; a < TAPS; a++) wcoef(a, 64);
    for (int i = 0; i < 4; i++) begin
      xfer(400, "avg");
      if (i > 0)
        chk("avg_thru", (t_acc - t_prev) / 10, TAPS+2);
    end

    do_reset();
    wcoef(0, 32767);
    xfer(32767, "sat_pos");
    chk("sat_ovf", ovf, m_ovf);
    xfer(10, "sat_in");
    chk("sat_ovf_hold", ovf, 1);
    xfer(-32768, "sat_neg");

    out_ready = 1'b0;
    send(11);
    wait_out(c);
    chk("stl_lat", c, TAPS+1);
    repeat (10) tick();
    chk("stl_vld", out_valid, 1);
    chk("stl_data", $signed(out_data), q[0]);
    chk("stl_rdy", in_ready, 0);
    chk("stl_cnt", sample_cnt, exp_cnt);
    out_ready = 1'b1;
    take("stl");
    tick();
    exp_cnt++;
    chk("stl_cnt2", sample_cnt, exp_cnt);

    do_reset();
    coef_we   = 1'b1;
    coef_addr = 2'd1;
    coef_data = 16'd128;
    in_valid  = 1'b1;
    in_data   = 16'd20;
    #1;
    chk("cw_rdy0", in_ready, 0);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    m_c[1] = 128;
    #1;
    chk("cw_rdy1", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mpush(20);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 16'd999;
    tick();
    coef_we = 1'b0;
    wait_out(c);
    chk("cw_lat", c + 1, TAPS+1);
    take("cw0");
    tick();
    exp_cnt++;
    xfer(30, "cw1");

    send(50);
    tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("en_frz_vld", out_valid, 0);
    enable = 1'b1;
    wait_out(c);
    chk("en_vld", out_valid, 1);
    enable = 1'b0;
    tick();
    chk("en_hold_vld", out_valid, 1);
    chk("en_hold_cnt", sample_cnt, exp_cnt);
    chk("en_rdy", in_ready, 0);
    enable = 1'b1;
    take("en");
    tick();
    exp_cnt++;
    chk("en_cnt", sample_cnt, exp_cnt);

    send(60);
    tick();
    rst = 1'b0;
    tick();
    chk("rm_vld", out_valid, 0);
    chk("rm_rdy", in_ready, 0);
    rst = 1'b1;
    mreset();
    #1;
    chk("rm_idle", in_ready, 1);
    repeat (6) tick();
    chk("rm_nout", out_valid, 0);
    chk("rm_cnt", sample_cnt, 0);
    xfer(77, "rm_id");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
